// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Command-driven load-then-shift controller for an 8-bit
//               universal shift register. Optional rotate fill is enabled
//               by defining SHIFT_SEQUENCER_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             c,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cmd_d,
    input  logic             cmd_dir,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] q,
    output logic             reg_l,
    output logic             reg_r,
    output logic             reg_i,
    output logic [WIDTH-1:0] reg_d,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [AMT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] c_CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_OP_ZERO  = 2'b00;
    localparam logic [1:0] c_OP_ONE   = 2'b01;
    localparam logic [1:0] c_OP_ARITH = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic [1:0]       r_op;
    logic             w_fill;

    always_ff @(posedge c) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= c_CNT_ZERO;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == c_IDLE && start) begin
                r_data <= cmd_d;
                r_dir  <= cmd_dir;
                r_op   <= cmd_op;
                r_cnt  <= cmd_amt;
            end else if (r_state == c_SHIFT) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        reg_l  = 1'b0;
        reg_r  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            c_IDLE: begin
                busy = 1'b0;
                if (start) w_next = c_LOAD;
            end
            c_LOAD: begin
                reg_l  = 1'b1;
                reg_r  = 1'b1;
                w_next = (r_cnt != c_CNT_ZERO) ? c_SHIFT : c_DONE;
            end
            c_SHIFT: begin
                reg_l = r_dir;
                reg_r = ~r_dir;
                // Last shift happens on the edge that leaves this state.
                if (r_cnt == c_CNT_ONE) w_next = c_DONE;
            end
            default: begin
                done   = 1'b1;
                w_next = c_IDLE;
            end
        endcase
    end

    // Fill bit entering the vacated end of the register.
    always_comb begin
        w_fill = 1'b0;
        case (r_op)
            c_OP_ZERO:  w_fill = 1'b0;
            c_OP_ONE:   w_fill = 1'b1;
            c_OP_ARITH: w_fill = r_dir ? 1'b0 : q[WIDTH-1];
            default: begin
`ifdef SHIFT_SEQUENCER_ROTATE_EN
                w_fill = r_dir ? q[WIDTH-1] : q[0];
`else
                w_fill = 1'b0;
`endif
            end
        endcase
    end

`ifndef SHIFT_SEQUENCER_ROTATE_EN
    logic w_unused_q;
    assign w_unused_q = &{1'b0, q[WIDTH-2:0]};
`endif

    assign reg_i = (r_state == c_SHIFT) ? w_fill : 1'b0;
    assign reg_d = r_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed bench for shift_sequencer driving a behavioural
//               universal shift register from the sequencer outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic       c = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cmd_d;
    logic       cmd_dir;
    logic [2:0] cmd_amt;
    logic [1:0] cmd_op;
    logic [7:0] q = 8'h00;
    logic       reg_l, reg_r, reg_i, busy, done;
    logic [7:0] reg_d;

    int n_vec = 0;
    int n_err = 0;

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .c(c), .rst(rst), .start(start), .cmd_d(cmd_d), .cmd_dir(cmd_dir),
        .cmd_amt(cmd_amt), .cmd_op(cmd_op), .q(q), .reg_l(reg_l), .reg_r(reg_r),
        .reg_i(reg_i), .reg_d(reg_d), .busy(busy), .done(done)
    );

    always #5 c = ~c;

    // Universal shift register under control of the sequencer (never reset).
    always @(posedge c) begin
        case ({reg_l, reg_r})
            2'b01:   q <= {reg_i, q[7:1]};
            2'b10:   q <= {q[6:0], reg_i};
            2'b11:   q <= reg_d;
            default: q <= q;
        endcase
    end

    typedef struct {
        logic [7:0] d;
        logic       dir;
        logic [2:0] amt;
        logic [1:0] op;
        logic [7:0] exp_q;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to done; lat counts cycles from the
    // start edge (cycle 1 = LOAD) up to and including the done cycle.
    task automatic run_cmd(input logic [7:0] d, input logic dir, input logic [2:0] amt,
                           input logic [1:0] op, output logic [7:0] qo, output int lat,
                           output int bcnt, output int scnt, output bit seen);
        @(negedge c);
        start = 1'b1; cmd_d = d; cmd_dir = dir; cmd_amt = amt; cmd_op = op;
        @(posedge c);
        lat = 0; bcnt = 0; scnt = 0; seen = 1'b0; qo = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge c);
            if (k == 1) start = 1'b0;
            lat = k;
            if (busy) bcnt++;
            if (reg_l ^ reg_r) scnt++;
            if (done) begin
                qo = q;
                seen = 1'b1;
                break;
            end
        end
    endtask

    vec_t vecs[9];

    initial begin
        logic [7:0] qo;
        int lat, bcnt, scnt, k;
        bit seen, any_done;
        logic [7:0] frozen;

        vecs[0] = '{8'hB4, 1'b0, 3'd3, 2'b00, 8'h16};
        vecs[1] = '{8'hB4, 1'b0, 3'd2, 2'b10, 8'hED};
        vecs[2] = '{8'h34, 1'b0, 3'd2, 2'b10, 8'h0D};
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        vecs[3] = '{8'h81, 1'b1, 3'd1, 2'b11, 8'h03};
        vecs[4] = '{8'h01, 1'b0, 3'd1, 2'b11, 8'h80};
`else
        vecs[3] = '{8'h81, 1'b1, 3'd1, 2'b11, 8'h02};
        vecs[4] = '{8'h01, 1'b0, 3'd1, 2'b11, 8'h00};
`endif
        vecs[5] = '{8'h00, 1'b1, 3'd7, 2'b01, 8'h7F};
        vecs[6] = '{8'h5A, 1'b1, 3'd0, 2'b01, 8'h5A};
        vecs[7] = '{8'h00, 1'b0, 3'd4, 2'b01, 8'hF0};
        vecs[8] = '{8'hC3, 1'b1, 3'd2, 2'b10, 8'h0C};

        rst = 1'b1; start = 1'b0; cmd_d = 8'h00; cmd_dir = 1'b0; cmd_amt = 3'd0; cmd_op = 2'b00;
        repeat (3) @(posedge c);
        @(negedge c);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_mode", int'({reg_l, reg_r}), 0);
        check("reset_reg_i", int'(reg_i), 0);
        check("reset_reg_d", int'(reg_d), 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].d, vecs[i].dir, vecs[i].amt, vecs[i].op, qo, lat, bcnt, scnt, seen);
            check($sformatf("v%0d_done_seen", i), int'(seen), 1);
            check($sformatf("v%0d_q", i), int'(qo), int'(vecs[i].exp_q));
            check($sformatf("v%0d_latency", i), lat, int'(vecs[i].amt) + 2);
            check($sformatf("v%0d_busy_cycles", i), bcnt, int'(vecs[i].amt) + 2);
            check($sformatf("v%0d_shift_cycles", i), scnt, int'(vecs[i].amt));
            check($sformatf("v%0d_reg_d", i), int'(reg_d), int'(vecs[i].d));
        end

        // Start during SHIFT must be ignored.
        @(negedge c);
        start = 1'b1; cmd_d = 8'hA5; cmd_dir = 1'b0; cmd_amt = 3'd5; cmd_op = 2'b00;
        @(posedge c);
        seen = 1'b0; lat = 0; qo = 8'h00;
        for (int j = 1; j <= 20; j++) begin
            @(negedge c);
            start = (j == 3);
            if (j == 3) begin cmd_d = 8'hFF; cmd_amt = 3'd1; cmd_op = 2'b01; end
            lat = j;
            if (done) begin qo = q; seen = 1'b1; break; end
        end
        start = 1'b0;
        check("ign_done_seen", int'(seen), 1);
        check("ign_q", int'(qo), 8'h05);
        check("ign_latency", lat, 7);
        check("ign_reg_d", int'(reg_d), 8'hA5);
        @(negedge c);
        check("ign_idle_after", int'(busy), 0);

        // Reset during SHIFT: shifts at E2 and E3, then frozen.
        @(negedge c);
        start = 1'b1; cmd_d = 8'hF0; cmd_dir = 1'b0; cmd_amt = 3'd6; cmd_op = 2'b00;
        @(posedge c);
        @(negedge c); start = 1'b0;
        @(negedge c);
        @(negedge c);
        rst = 1'b1;
        @(posedge c);
        @(negedge c);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_mode", int'({reg_l, reg_r}), 0);
        check("rst_q", int'(q), 8'h3C);
        frozen = q;
        any_done = 1'b0;
        for (k = 0; k < 8; k++) begin
            @(negedge c);
            if (done) any_done = 1'b1;
        end
        check("rst_no_done", int'(any_done), 0);
        check("rst_q_frozen", int'(q), int'(frozen));

        // Reset and start together: command dropped.
        @(negedge c);
        start = 1'b1; rst = 1'b1; cmd_d = 8'h99; cmd_amt = 3'd1;
        @(posedge c);
        @(negedge c);
        start = 1'b0; rst = 1'b0;
        check("rst_start_busy", int'(busy), 0);
        check("rst_start_reg_d", int'(reg_d), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
